// File: rtl/comparator_if.sv
// Purpose: operand/result bundle for the registered magnitude comparator.
// Latency: n/a (wiring only); results trail their operands by one clock.
// Backpressure: none; the producer may present one operand pair every cycle.
//
// Signals:
//   in_valid, signed_mode, A, B        : producer -> comparator
//   AequalB, greater, lesser, out_valid,
//   diff                               : comparator -> consumer
interface comparator_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic             signed_mode;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             AequalB;
    logic             greater;
    logic             lesser;
    logic             out_valid;
    logic [WIDTH-1:0] diff;

    // Producer side: drives operands, observes results.
    modport master (
        output in_valid, signed_mode, A, B,
        input  AequalB, greater, lesser, out_valid, diff
    );

    // Comparator side.
    modport slave (
        input  in_valid, signed_mode, A, B,
        output AequalB, greater, lesser, out_valid, diff
    );
endinterface

// File: rtl/comparator.sv
// Purpose: registered compare of A vs B (signed or unsigned) with |A-B| magnitude.
// Latency: one clock from an in_valid capture to out_valid and all result outputs.
// Backpressure: none; accepts a new pair every cycle, results hold while in_valid=0.
//
// Ports:
//   clk  : single clock, rising edge
//   rst  : synchronous active-high reset, wins over a coincident capture
//   bus  : comparator_if.slave carrying in_valid/signed_mode/A/B in and
//          AequalB/greater/lesser/out_valid/diff out (all outputs registered)
// Parameters:
//   WIDTH     : operand width, 1..32
//   SIGNED_EN : 0 ties the compare to unsigned regardless of signed_mode
module comparator #(
    parameter int WIDTH     = 4,
    parameter int SIGNED_EN = 1
) (
    input  logic          clk,
    input  logic          rst,
    comparator_if.slave   bus
);
    localparam bit SignedAllowed = (SIGNED_EN != 0);

    logic             signedEff;
    logic [WIDTH:0]   aExt;
    logic [WIDTH:0]   bExt;
    logic             aEqB;
    logic             aGtB;
    logic             aLtB;
    logic [WIDTH-1:0] magnitude;

    logic             eqQ;
    logic             gtQ;
    logic             ltQ;
    logic             validQ;
    logic [WIDTH-1:0] diffQ;

    always_comb begin
        signedEff = SignedAllowed && bus.signed_mode;

        // One extra bit lets a single signed compare cover both modes:
        // sign-extend in signed mode, zero-extend in unsigned mode.
        aExt = {signedEff & bus.A[WIDTH-1], bus.A};
        bExt = {signedEff & bus.B[WIDTH-1], bus.B};

        // Equality is bitwise and therefore mode independent.
        aEqB = (bus.A == bus.B);
        aGtB = ($signed(aExt) > $signed(bExt));
        aLtB = !aEqB && !aGtB;

        // The true magnitude never exceeds 2^WIDTH-1, so subtracting the
        // smaller from the larger modulo 2^WIDTH gives the exact value in
        // either mode; the wrap of the raw subtraction cancels out.
        magnitude = aGtB ? (bus.A - bus.B) : (bus.B - bus.A);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            eqQ    <= 1'b0;
            gtQ    <= 1'b0;
            ltQ    <= 1'b0;
            validQ <= 1'b0;
            diffQ  <= '0;
        end else begin
            validQ <= bus.in_valid;
            if (bus.in_valid) begin
                eqQ   <= aEqB;
                gtQ   <= aGtB;
                ltQ   <= aLtB;
                diffQ <= magnitude;
            end
        end
    end

    assign bus.AequalB   = eqQ;
    assign bus.greater   = gtQ;
    assign bus.lesser    = ltQ;
    assign bus.out_valid = validQ;
    assign bus.diff      = diffQ;
endmodule

// File: tb/tb_comparator.sv
// Purpose: randomized and directed self-checking bench for comparator (WIDTH=4).
// Latency: expects every captured pair on the outputs one clock later.
// Backpressure: none exercised; the design has no ready path.
module tb_comparator;
    localparam int W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    // Last captured result of the signed-capable DUT: {eq, gt, lt, diff}.
    logic [6:0] lastRes = '0;

    always #5 clk = ~clk;

    comparator_if #(.WIDTH(W)) ifc ();
    comparator_if #(.WIDTH(W)) ifcU ();

    comparator #(.WIDTH(W), .SIGNED_EN(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    comparator #(.WIDTH(W), .SIGNED_EN(0)) dutU (
        .clk (clk),
        .rst (rst),
        .bus (ifcU.slave)
    );

    // Reference: interpret operands as integers, compare, take absolute
    // difference. Returns {out_valid, eq, gt, lt, diff}.
    function automatic logic [7:0] model(input int a, input int b, input bit sgn);
        int av;
        int bv;
        int d;
        av = (sgn && a >= (1 << (W - 1))) ? a - (1 << W) : a;
        bv = (sgn && b >= (1 << (W - 1))) ? b - (1 << W) : b;
        d  = (av > bv) ? av - bv : bv - av;
        return {1'b1, av == bv, av > bv, av < bv, d[W-1:0]};
    endfunction

    function automatic logic [7:0] obs();
        return {ifc.out_valid, ifc.AequalB, ifc.greater, ifc.lesser, ifc.diff};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input bit sgn, input int a, input int b);
        ifc.in_valid    = v;
        ifc.signed_mode = sgn;
        ifc.A           = a[W-1:0];
        ifc.B           = b[W-1:0];
    endtask

    task automatic test_reset();
        logic [7:0] exp;
        // Held in reset: everything must read zero.
        checks++;
        if (obs() !== 8'h00) begin
            errors++;
            $display("FAIL reset_state got=%b want=%b", obs(), 8'h00);
        end
        // Capture coincident with rst is discarded.
        drive(1'b1, 1'b0, 9, 2);
        tick();
        checks++;
        if (obs() !== 8'h00) begin
            errors++;
            $display("FAIL reset_priority got=%b want=%b", obs(), 8'h00);
        end
        // First edge after release accepts the pair.
        rst = 1'b0;
        tick();
        exp = model(9, 2, 1'b0);
        checks++;
        if (obs() !== exp) begin
            errors++;
            $display("FAIL reset_first_capture got=%b want=%b", obs(), exp);
        end
        lastRes = exp[6:0];
    endtask

    task automatic test_unsigned_sweep();
        logic [7:0] exp;
        int bad = 0;
        for (int a = 0; a < (1 << W); a++) begin
            for (int b = 0; b < (1 << W); b++) begin
                drive(1'b1, 1'b0, a, b);
                tick();
                exp = model(a, b, 1'b0);
                checks++;
                if (obs() !== exp) begin
                    errors++;
                    bad++;
                    if (bad <= 8)
                        $display("FAIL unsigned_sweep a=%0d b=%0d got=%b want=%b", a, b, obs(), exp);
                end
                lastRes = exp[6:0];
            end
        end
    endtask

    task automatic test_signed_corners();
        int pairs [4][2] = '{'{8, 7}, '{7, 8}, '{15, 0}, '{8, 8}};
        logic [7:0] want [4] = '{8'b1001_1111, 8'b1010_1111, 8'b1001_0001, 8'b1100_0000};
        logic [7:0] exp;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, pairs[i][0], pairs[i][1]);
            tick();
            exp = model(pairs[i][0], pairs[i][1], 1'b1);
            checks++;
            if (obs() !== want[i] || obs() !== exp) begin
                errors++;
                $display("FAIL signed_corner%0d got=%b want=%b", i, obs(), want[i]);
            end
            lastRes = exp[6:0];
        end
    endtask

    task automatic test_mode_switch();
        drive(1'b1, 1'b0, 15, 1);
        tick();
        checks++;
        if (obs() !== 8'b1010_1110) begin
            errors++;
            $display("FAIL mode_switch_unsigned got=%b want=%b", obs(), 8'b1010_1110);
        end
        drive(1'b1, 1'b1, 15, 1);
        tick();
        checks++;
        if (obs() !== 8'b1001_0010) begin
            errors++;
            $display("FAIL mode_switch_signed got=%b want=%b", obs(), 8'b1001_0010);
        end
        lastRes = 7'b001_0010;
    endtask

    task automatic test_hold();
        logic [7:0] exp;
        drive(1'b1, 1'b0, 3, 5);
        tick();
        exp = 8'b1001_0010;
        checks++;
        if (obs() !== exp) begin
            errors++;
            $display("FAIL hold_capture got=%b want=%b", obs(), exp);
        end
        for (int i = 0; i < 4; i++) begin
            // Operands change while invalid; they must be ignored.
            drive(1'b0, 1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom_range(0, 15));
            tick();
            checks++;
            if (obs() !== 8'b0001_0010) begin
                errors++;
                $display("FAIL hold_cycle%0d got=%b want=%b", i, obs(), 8'b0001_0010);
            end
        end
        lastRes = 7'b001_0010;
    endtask

    task automatic test_random();
        logic [7:0] exp;
        int a;
        int b;
        bit v;
        bit s;
        bit r;
        int bad = 0;
        for (int i = 0; i < 400; i++) begin
            r = (i == 0) || ($urandom_range(0, 19) == 0);
            v = ($urandom_range(0, 3) != 0);
            s = 1'($urandom_range(0, 1));
            a = $urandom_range(0, 15);
            b = $urandom_range(0, 15);
            rst = r;
            drive(v, s, a, b);
            tick();
            if (r) begin
                exp = 8'h00;
                lastRes = '0;
            end else if (v) begin
                exp = model(a, b, s);
                lastRes = exp[6:0];
            end else begin
                exp = {1'b0, lastRes};
            end
            checks++;
            if (obs() !== exp) begin
                errors++;
                bad++;
                if (bad <= 8)
                    $display("FAIL random i=%0d rst=%0d v=%0d s=%0d a=%0d b=%0d got=%b want=%b",
                             i, r, v, s, a, b, obs(), exp);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_signed_disabled();
        logic [7:0] exp;
        logic [7:0] got;
        int a;
        int b;
        ifc.in_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            a = (i == 0) ? 15 : $urandom_range(0, 15);
            b = (i == 0) ? 1 : $urandom_range(0, 15);
            ifcU.in_valid    = 1'b1;
            ifcU.signed_mode = 1'b1;
            ifcU.A           = a[W-1:0];
            ifcU.B           = b[W-1:0];
            tick();
            exp = model(a, b, 1'b0);
            got = {ifcU.out_valid, ifcU.AequalB, ifcU.greater, ifcU.lesser, ifcU.diff};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL signed_disabled a=%0d b=%0d got=%b want=%b", a, b, got, exp);
            end
        end
        ifcU.in_valid = 1'b0;
    endtask

    initial begin
        drive(1'b0, 1'b0, 0, 0);
        ifcU.in_valid    = 1'b0;
        ifcU.signed_mode = 1'b0;
        ifcU.A           = '0;
        ifcU.B           = '0;
        rst = 1'b1;
        tick();
        tick();
        test_reset();
        test_unsigned_sweep();
        test_signed_corners();
        test_mode_switch();
        test_hold();
        test_random();
        test_signed_disabled();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
